// File: rtl/key_conditioner.sv
// Per-key push-button conditioner: two-flop synchroniser, debounce FSM, and registered
// level / press / release / long-hold / toggle outputs for active-low board KEYs.
module key_conditioner #(
  parameter int unsigned NKeys          = 2,
  parameter int unsigned DebounceCycles = 1000000,
  parameter int unsigned HoldCycles     = 50000000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NKeys-1:0] key_i,
  output logic [NKeys-1:0] key_level_o,
  output logic [NKeys-1:0] key_press_o,
  output logic [NKeys-1:0] key_release_o,
  output logic [NKeys-1:0] key_hold_o,
  output logic [NKeys-1:0] key_toggle_o
);

  localparam int unsigned CntW  = $clog2(DebounceCycles + 1);
  localparam int unsigned HoldW = $clog2(HoldCycles + 1);
  localparam logic [CntW-1:0]  CntLast = CntW'(DebounceCycles - 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HoldCycles);

  typedef enum logic [1:0] {StUp, StDownWait, StDown, StUpWait} state_e;

  // Synchroniser resets to released (1) so a held key after reset looks like a fresh press.
  logic [NKeys-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < NKeys; i++) begin : gen_key
    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic             press_d, release_d, hold_d;
    logic             level_q, press_q, release_q, hold_q, toggle_q;
    logic             pressed;

    assign pressed = ~sync2_q[i];

    always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hold_cnt_d = hold_cnt_q;
      press_d    = 1'b0;
      release_d  = 1'b0;
      hold_d     = 1'b0;
      unique case (state_q)
        StUp: begin
          if (pressed) begin
            state_d = StDownWait;
            cnt_d   = CntW'(1);
          end
        end
        StDownWait: begin
          if (!pressed) begin
            state_d = StUp;
          end else if (cnt_q == CntLast) begin
            state_d    = StDown;
            press_d    = 1'b1;
            hold_cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StDown: begin
          // Saturating hold count; the pulse marks the single cycle it reaches the limit.
          if (hold_cnt_q != HoldMax) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
            hold_d     = (hold_cnt_q == HoldMax - 1'b1);
          end
          if (!pressed) begin
            state_d = StUpWait;
            cnt_d   = CntW'(1);
          end
        end
        StUpWait: begin
          if (pressed) begin
            state_d = StDown;
          end else if (cnt_q == CntLast) begin
            state_d   = StUp;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = StUp;
      endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q    <= StUp;
        cnt_q      <= '0;
        hold_cnt_q <= '0;
        level_q    <= 1'b0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        hold_q     <= 1'b0;
        toggle_q   <= 1'b0;
      end else begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        hold_cnt_q <= hold_cnt_d;
        level_q    <= (state_d == StDown) || (state_d == StUpWait);
        press_q    <= press_d;
        release_q  <= release_d;
        hold_q     <= hold_d;
        toggle_q   <= toggle_q ^ press_d;
      end
    end

    assign key_level_o[i]   = level_q;
    assign key_press_o[i]   = press_q;
    assign key_release_o[i] = release_q;
    assign key_hold_o[i]    = hold_q;
    assign key_toggle_o[i]  = toggle_q;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: run-length debounce model checked every cycle, plus directed
// scenarios with hand-computed latencies and pulse counts.
module tb_key_conditioner;

  localparam int NK   = 2;
  localparam int DEB  = 4;
  localparam int HOLD = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NK-1:0] key_in = '1;
  logic [NK-1:0] dut_level, dut_press, dut_rel, dut_hold, dut_tog;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model state: raw-input pipeline, accepted level, run of disagreeing samples, hold count.
  logic [NK-1:0] m_s1, m_s2, m_level, m_tog, m_press, m_rel, m_hold;
  int            m_run [NK];
  int            m_hcnt[NK];
  int            obs_press[NK], obs_rel[NK], obs_hold[NK];

  key_conditioner #(
    .NKeys         (NK),
    .DebounceCycles(DEB),
    .HoldCycles    (HOLD)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .key_i        (key_in),
    .key_level_o  (dut_level),
    .key_press_o  (dut_press),
    .key_release_o(dut_rel),
    .key_hold_o   (dut_hold),
    .key_toggle_o (dut_tog)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_s1 = '1; m_s2 = '1; m_level = '0; m_tog = '0;
    m_press = '0; m_rel = '0; m_hold = '0;
    for (int i = 0; i < NK; i++) begin
      m_run[i]  = 0;
      m_hcnt[i] = 0;
    end
  endtask

  // A change is accepted once DEB consecutive synchronised samples disagree with the level.
  task automatic model_edge();
    logic s;
    bit   in_down;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_press = '0; m_rel = '0; m_hold = '0;
    for (int i = 0; i < NK; i++) begin
      s       = ~m_s2[i];
      in_down = m_level[i] && (m_run[i] == 0);
      if (in_down && m_hcnt[i] < HOLD) begin
        m_hcnt[i]++;
        if (m_hcnt[i] == HOLD) m_hold[i] = 1'b1;
      end
      if (s != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_level[i] = s;
          m_run[i]   = 0;
          if (s) begin
            m_press[i] = 1'b1;
            m_tog[i]   = ~m_tog[i];
            m_hcnt[i]  = 0;
          end else begin
            m_rel[i] = 1'b1;
          end
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = key_in;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check("level",   dut_level, m_level);
    check("press",   dut_press, m_press);
    check("release", dut_rel,   m_rel);
    check("hold",    dut_hold,  m_hold);
    check("toggle",  dut_tog,   m_tog);
    for (int i = 0; i < NK; i++) begin
      obs_press[i] += int'(dut_press[i]);
      obs_rel[i]   += int'(dut_rel[i]);
      obs_hold[i]  += int'(dut_hold[i]);
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Returns the number of edges taken (including the first) until the pulse is seen, or -1.
  task automatic wait_pulse(input int kind, input int idx, output int n);
    logic [NK-1:0] v;
    n = -1;
    for (int k = 1; k <= 100; k++) begin
      step();
      case (kind)
        0:       v = dut_press;
        1:       v = dut_rel;
        default: v = dut_hold;
      endcase
      if (v[idx]) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_level"},   dut_level, 0);
    check({name, "_press"},   dut_press, 0);
    check({name, "_release"}, dut_rel,   0);
    check({name, "_hold"},    dut_hold,  0);
    check({name, "_toggle"},  dut_tog,   0);
  endtask

  initial begin
    int           n;
    int           p0, r0, h0;
    logic [2:0]   tog_pat;
    model_reset();
    for (int i = 0; i < NK; i++) begin
      obs_press[i] = 0; obs_rel[i] = 0; obs_hold[i] = 0;
    end

    #1 rst_n = 1'b0;
    #1 check_all_zero("reset");
    steps(2);
    #4 rst_n = 1'b1;
    steps(3);

    // Clean press on key 0: E0 plus five more edges.
    key_in[0] = 1'b0;
    wait_pulse(0, 0, n);
    check("press_latency", n, 6);
    check("press_level0", dut_level[0], 1);
    check("press_toggle0", dut_tog[0], 1);
    steps(4);
    key_in[0] = 1'b1;
    wait_pulse(1, 0, n);
    check("release_latency", n, 6);
    check("release_level0", dut_level[0], 0);
    steps(3);

    // Bounce on key 1 shorter than the debounce window.
    key_in[1] = 1'b0; step();
    key_in[1] = 1'b1; step();
    key_in[1] = 1'b0; step();
    key_in[1] = 1'b1;
    steps(10);
    check("bounce_level1", dut_level[1], 0);
    check("bounce_press1", obs_press[1], 0);
    check("bounce_rel1", obs_rel[1], 0);

    // Long hold: one hold pulse 20 edges after press, none afterwards.
    h0 = obs_hold[0];
    key_in[0] = 1'b0;
    wait_pulse(0, 0, n);
    check("hold_press_latency", n, 6);
    wait_pulse(2, 0, n);
    check("hold_latency", n, 20);
    steps(20);
    check("hold_once", obs_hold[0] - h0, 1);
    key_in[0] = 1'b1;
    wait_pulse(1, 0, n);
    check("hold_release_latency", n, 6);
    steps(3);

    // Two-cycle high glitch in the middle of a held press.
    p0 = obs_press[0];
    r0 = obs_rel[0];
    key_in[0] = 1'b0;
    wait_pulse(0, 0, n);
    steps(3);
    key_in[0] = 1'b1;
    steps(2);
    key_in[0] = 1'b0;
    steps(10);
    check("glitch_level0", dut_level[0], 1);
    check("glitch_press_count", obs_press[0] - p0, 1);
    check("glitch_rel_count", obs_rel[0] - r0, 0);
    key_in[0] = 1'b1;
    wait_pulse(1, 0, n);
    check("glitch_release_latency", n, 6);
    steps(3);

    // Three presses on key 1: toggle goes 1,0,1; key 0 toggle (three presses so far) stays 1.
    tog_pat = 3'b101;
    for (int k = 0; k < 3; k++) begin
      key_in[1] = 1'b0;
      wait_pulse(0, 1, n);
      check("toggle_press_latency", n, 6);
      check("toggle1", dut_tog[1], tog_pat[k]);
      check("toggle0_steady", dut_tog[0], 1);
      key_in[1] = 1'b1;
      wait_pulse(1, 1, n);
      steps(2);
    end

    // Simultaneous press and release of both keys.
    key_in = 2'b00;
    wait_pulse(0, 0, n);
    check("simul_latency", n, 6);
    check("simul_press", dut_press, 2'b11);
    check("simul_toggle", dut_tog, 2'b00);
    key_in = 2'b11;
    wait_pulse(1, 0, n);
    check("simul_release", dut_rel, 2'b11);
    steps(3);

    // Asynchronous reset while key 0 is down; still-held key yields a fresh press.
    key_in[0] = 1'b0;
    wait_pulse(0, 0, n);
    steps(2);
    check("pre_reset_level0", dut_level[0], 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all_zero("async_reset");
    #1 rst_n = 1'b1;
    wait_pulse(0, 0, n);
    check("post_reset_press_latency", n, 6);
    check("post_reset_toggle0", dut_tog[0], 1);
    key_in[0] = 1'b1;
    wait_pulse(1, 0, n);
    check("post_reset_release_latency", n, 6);
    steps(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Conditions the raw DE10-Lite push-buttons before they reach the display/LED top level. Each active-low KEY is synchronised, debounced, and turned into a clean level plus one-cycle press, release and long-hold pulses, and a press-toggled latch. The top level consumes these outputs instead of raw KEY bits: KEY_TOGGLE[1] selects which birthday is shown, and KEY_PRESS[0] strobes the switch-to-LED capture.

## Interface
- N_KEYS, 2, number of independent buttons conditioned
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised samples required to accept a change (20 ms at 50 MHz)
- HOLD_CYCLES, 50000000, cycles in DOWN before KEY_HOLD fires (1 s at 50 MHz); must exceed DEBOUNCE_CYCLES

- CLK  in  1  system clock, 50 MHz board oscillator
- RST_N  in  1  asynchronous, active-low reset; one clock domain, no other reset
- KEY_IN  in  N_KEYS  raw buttons, active-low (0 = pressed), asynchronous to CLK
- KEY_LEVEL  out  N_KEYS  debounced state, active-high (1 = pressed)
- KEY_PRESS  out  N_KEYS  one-cycle pulse on an accepted press
- KEY_RELEASE  out  N_KEYS  one-cycle pulse on an accepted release
- KEY_HOLD  out  N_KEYS  one-cycle pulse, at most once per press, after HOLD_CYCLES held
- KEY_TOGGLE  out  N_KEYS  level that inverts on every KEY_PRESS

## Operation
- Each key has its own independent channel; channels share only CLK and RST_N.
- Synchroniser: two flops per key, reset to 1 (released). Inverted output s = 1 means pressed.
- Per-key FSM, states UP, DOWN_WAIT, DOWN, UP_WAIT; debounce counter width $clog2(DEBOUNCE_CYCLES+1).
  - UP: s=1 -> DOWN_WAIT, cnt=1; else stay.
  - DOWN_WAIT: s=0 -> UP (bounce, no pulse); s=1 and cnt=DEBOUNCE_CYCLES-1 -> DOWN; else cnt+1.
  - DOWN: s=0 -> UP_WAIT, cnt=1; else stay.
  - UP_WAIT: s=1 -> DOWN (bounce, no pulse, no new press); s=0 and cnt=DEBOUNCE_CYCLES-1 -> UP; else cnt+1.
- KEY_LEVEL = 1 in DOWN and UP_WAIT, 0 in UP and DOWN_WAIT. All outputs are registered.
- KEY_PRESS is high for exactly the first cycle in DOWN after leaving DOWN_WAIT. KEY_RELEASE is high for the first cycle in UP after leaving UP_WAIT.
- Hold counter width $clog2(HOLD_CYCLES+1):
  - Cleared on DOWN_WAIT->DOWN.
  - Increments each cycle in DOWN, freezes in UP_WAIT, saturates at HOLD_CYCLES.
  - KEY_HOLD pulses in the single cycle the counter reaches HOLD_CYCLES.
  - No further KEY_HOLD until the next accepted press.
- KEY_TOGGLE[i] flips in the same cycle KEY_PRESS[i] is high. Release and hold do not affect it.
- Simultaneous events: keys pressed on the same edge produce same-cycle pulses on both channels. A hold pulse and a release pulse cannot coincide on one key, because hold fires only in DOWN.

## Timing
- Reset (RST_N=0, asynchronous): every FSM in UP, all counters 0, synchroniser flops 1. KEY_LEVEL, KEY_PRESS, KEY_RELEASE, KEY_HOLD and KEY_TOGGLE all read 0 immediately. Deassertion is taken on the next CLK edge.
- Press latency: edge E0 is the first edge sampling KEY_IN=0, and the input stays low. KEY_PRESS and KEY_LEVEL rise after edge E0+1+DEBOUNCE_CYCLES, i.e. 2 sync edges plus the debounce count.
- Release latency: identical, measured from the first edge sampling KEY_IN=1.
- Hold: KEY_HOLD rises HOLD_CYCLES edges after KEY_PRESS, provided there is no UP_WAIT residency. Each cycle spent in UP_WAIT adds one cycle.
- A glitch shorter than DEBOUNCE_CYCLES synchronised samples produces no output change.
- Reset mid-press: all outputs drop to 0 asynchronously. A button still held after reset produces a fresh KEY_PRESS after the full press latency.

## Test plan
Run with DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, N_KEYS=2.
- Clean press: KEY_IN[0] held low from E0 -> KEY_PRESS[0] and KEY_LEVEL[0] rise after E0+5, KEY_TOGGLE[0]=1. Release from E10 -> KEY_RELEASE[0] rises after E10+5, KEY_LEVEL[0]=0.
- Bounce: KEY_IN[1] toggles 0,1,0,1 on single cycles, then stays 1 -> no pulses, KEY_LEVEL[1] stays 0. During a held press, a 2-cycle high glitch -> KEY_LEVEL stays 1, no RELEASE, no second PRESS.
- Long hold: hold KEY_IN[0] low for 40 cycles -> exactly one KEY_HOLD[0], 20 cycles after KEY_PRESS[0], and no repeat while still held.
- Toggle: three separate press/release cycles on KEY_IN[1] -> KEY_TOGGLE[1] goes 1,0,1. KEY_TOGGLE[0] remains unchanged throughout.
- Simultaneous: both keys low on the same edge -> KEY_PRESS=2'b11 in one cycle.
- Reset mid-press: RST_N=0 while KEY_LEVEL[0]=1 -> all outputs 0 without waiting for a clock edge. After RST_N=1 with the key still held, KEY_PRESS[0] fires 5 edges later.
